flash_hexdump: RTL
==================

FLASH_HEXDUMP -- requirements
Module: flash_hexdump

Interface
REQ-001 SHALL have parameter WORD_BITS, default 8, flash/serial word width; SHALL be a multiple of 4.
REQ-002 SHALL have parameter ADDRESS_WORDS, default 3, address width in words (ADDR_BITS = WORD_BITS*ADDRESS_WORDS).
REQ-003 SHALL have parameter WORDS_PER_LINE, default 16, data words per dump line, range 1..64.
REQ-004 SHALL have parameter SHOW_ASCII, default 1, when 1 appends an ASCII column to each line.
REQ-005 SHALL have parameter HEX_UPPER, default 1, when 1 emits hex digits A-F, else a-f.
REQ-006 SHALL have ports: in_clk input 1 main clock; in_rst input 1 asynchronous active-low reset.
REQ-007 SHALL have ports: in_start input 1 start request; in_abort input 1 abort request; in_addr input ADDR_BITS first address; in_len input ADDR_BITS word count.
REQ-008 SHALL have ports: out_busy output 1 dump active; out_done output 1 one-cycle completion pulse.
REQ-009 SHALL have flash ports: out_flash_enable output 1; out_flash_addr output ADDR_BITS; in_flash_data input WORD_BITS; in_flash_word_finished input 1; in_flash_next_word input 1.
REQ-010 SHALL have serial ports: out_tx_enable output 1; out_tx_char output 8; in_tx_word_finished input 1.

Function
REQ-011 SHALL sample in_start only in Idle; start while busy SHALL be ignored; out_busy SHALL be high in every state except Idle.
REQ-012 SHALL complete in_len=0 with out_done the cycle after start, with no flash or serial activity.
REQ-013 SHALL emit each line as: address in ADDR_BITS/4 hex digits, ':', then per word ' ' plus WORD_BITS/4 hex digits, then (SHOW_ASCII) ' |', one char per word, '|', then '\r', '\n'.
REQ-014 SHALL map ASCII column bytes 0x20..0x7E (low 8 bits of word) to themselves and all others to '.'.
REQ-015 SHALL make the last line partial when in_len is not a multiple of WORDS_PER_LINE, with no padding.
REQ-016 SHALL use states Idle, FlashRead, TxAddr, TxColon, TxSep, TxData, TxAsciiOpen, TxAscii, TxAsciiClose, TxCR, TxNL, NextLine, Done.
REQ-017 SHALL in FlashRead hold out_flash_enable high with out_flash_addr = line address and capture in_flash_data into line buffer slot k on each rising edge of in_flash_word_finished.
REQ-018 SHALL deassert out_flash_enable in the cycle a rising edge of in_flash_next_word occurs while the line's last word is in flight, and leave FlashRead on the capture of that word.
REQ-019 SHALL in every Tx state hold out_tx_enable high with out_tx_char stable; on a rising edge of in_tx_word_finished SHALL drop out_tx_enable for that cycle and advance digit/word/state.
REQ-020 SHALL emit hex digits most-significant nibble first.
REQ-021 SHALL in NextLine add the line word count to the line address modulo 2^ADDR_BITS (wrap FFFFFF->000000), subtract it from the remaining count, and go to FlashRead if remaining>0, else Done.
REQ-022 SHALL pulse out_done for exactly one cycle in Done, then return to Idle.
REQ-023 SHALL on in_abort in any non-Idle state deassert both enables combinatorially and enter Idle next cycle without out_done; abort and start in the same Idle cycle SHALL start nothing.
REQ-024 SHALL derive all edges from registered previous values of in_flash_word_finished, in_flash_next_word, in_tx_word_finished.

Reset
REQ-025 SHALL on in_rst low immediately force state Idle, counters and line buffer zero, edge registers zero, out_busy/out_done/out_flash_enable/out_tx_enable 0, out_flash_addr 0, out_tx_char 0x20.
REQ-026 SHALL recover from reset asserted mid-dump with no residual transfer; a new start SHALL dump from in_addr.

Structure
REQ-027 SHALL place the state enum and ASCII constants (':', ' ', '|', '.', CR, NL) in shared package flash_hexdump_pkg.
REQ-028 SHALL implement nibble-to-ASCII conversion in sub-module hex_digit (4-bit in, HEX_UPPER parameter, 8-bit char out, combinational).
REQ-029 SHALL hold the line buffer as WORDS_PER_LINE x WORD_BITS registers.

Verification
REQ-030 start, addr=0x000010, len=4, flash returns 0x5A,0x41,0x00,0x7F -> serial "000010: 5A 41 00 7F |ZA..|\r\n", one out_done.
REQ-031 addr=0x000000, len=20, WORDS_PER_LINE=16 -> two lines, second begins "000010:" with 4 words; exactly 20 flash captures.
REQ-032 addr=0xFFFFFE, len=4, WORDS_PER_LINE=2 -> lines "FFFFFE:" and "000000:".
REQ-033 len=0 -> out_done one cycle after start, out_tx_enable and out_flash_enable never high.
REQ-034 in_abort during TxData of first line -> enables low same cycle, Idle next cycle, no out_done; following start completes normally.
REQ-035 in_rst low during FlashRead -> all outputs at reset values immediately; start pulse while busy ignored (one line only for len=1).

Source files
------------

// File: rtl/flash_hexdump_pkg.sv
// Shared definitions for the flash hex dumper.
//   state_t   : dump controller states
//   CH_*      : fixed ASCII characters used in the dump line format
//   is_tx_state / ascii_col : small helpers shared by the top level
package flash_hexdump_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_FLASH_READ,
    S_TX_ADDR,
    S_TX_COLON,
    S_TX_SEP,
    S_TX_DATA,
    S_TX_ASCII_OPEN,
    S_TX_ASCII,
    S_TX_ASCII_CLOSE,
    S_TX_CR,
    S_TX_NL,
    S_NEXT_LINE,
    S_DONE
  } state_t;

  localparam logic [7:0] CH_COLON = 8'h3A;
  localparam logic [7:0] CH_SPACE = 8'h20;
  localparam logic [7:0] CH_BAR   = 8'h7C;
  localparam logic [7:0] CH_DOT   = 8'h2E;
  localparam logic [7:0] CH_CR    = 8'h0D;
  localparam logic [7:0] CH_NL    = 8'h0A;

  // States in which a character is being offered to the serial side.
  function automatic logic is_tx_state(input state_t s);
    return s inside {S_TX_ADDR, S_TX_COLON, S_TX_SEP, S_TX_DATA,
                     S_TX_ASCII_OPEN, S_TX_ASCII, S_TX_ASCII_CLOSE,
                     S_TX_CR, S_TX_NL};
  endfunction

  // Printable bytes pass through, everything else shows as '.'.
  function automatic logic [7:0] ascii_col(input logic [7:0] b);
    return (b >= 8'h20 && b <= 8'h7E) ? b : CH_DOT;
  endfunction

endpackage

// File: rtl/flash_hexdump_hex_digit.sv
// hex_digit: combinational nibble -> ASCII hex character.
//   nibble : 4-bit value
//   ascii  : '0'..'9' then 'A'..'F' (HEX_UPPER=1) or 'a'..'f'
module hex_digit #(
  parameter int HEX_UPPER = 1
) (
  input  logic [3:0] nibble,
  output logic [7:0] ascii
);

  localparam logic [7:0] ALPHA_BASE = (HEX_UPPER != 0) ? 8'h41 : 8'h61;

  always_comb begin
    if (nibble < 4'd10) ascii = 8'h30 + {4'h0, nibble};
    else                ascii = ALPHA_BASE + {4'h0, nibble} - 8'd10;
  end

endmodule

// File: rtl/flash_hexdump.sv
// flash_hexdump: reads a range of flash words and streams a formatted
// hex dump, one line per WORDS_PER_LINE words, over a character link.
//   in_clk / in_rst          : clock, async active-low reset
//   in_start, in_addr, in_len: start a dump of in_len words from in_addr
//   in_abort                 : drop the dump, back to idle without done
//   out_busy / out_done      : activity flag, one-cycle completion pulse
//   out_flash_*, in_flash_*  : word reader handshake (edge based)
//   out_tx_*, in_tx_*        : character transmitter handshake (edge based)
module flash_hexdump
  import flash_hexdump_pkg::*;
#(
  parameter int WORD_BITS      = 8,
  parameter int ADDRESS_WORDS  = 3,
  parameter int WORDS_PER_LINE = 16,
  parameter int SHOW_ASCII     = 1,
  parameter int HEX_UPPER      = 1,
  localparam int ADDR_BITS     = WORD_BITS * ADDRESS_WORDS
) (
  input  logic                 in_clk,
  input  logic                 in_rst,
  input  logic                 in_start,
  input  logic                 in_abort,
  input  logic [ADDR_BITS-1:0] in_addr,
  input  logic [ADDR_BITS-1:0] in_len,
  output logic                 out_busy,
  output logic                 out_done,
  output logic                 out_flash_enable,
  output logic [ADDR_BITS-1:0] out_flash_addr,
  input  logic [WORD_BITS-1:0] in_flash_data,
  input  logic                 in_flash_word_finished,
  input  logic                 in_flash_next_word,
  output logic                 out_tx_enable,
  output logic [7:0]           out_tx_char,
  input  logic                 in_tx_word_finished
);

  localparam int ADDR_DIGITS = ADDR_BITS / 4;
  localparam int WORD_DIGITS = WORD_BITS / 4;
  localparam int CW = $clog2(WORDS_PER_LINE + 1);
  localparam int IW = (WORDS_PER_LINE > 1) ? $clog2(WORDS_PER_LINE) : 1;
  localparam int DW = $clog2(ADDR_DIGITS + 1);
  // A full line only limits the step when WORDS_PER_LINE is representable
  // in the address/count width; otherwise the remaining count always wins.
  localparam bit WPL_FITS = (ADDR_BITS >= 7) || (WORDS_PER_LINE < (1 << ADDR_BITS));

  state_t                                   state;
  logic [ADDR_BITS-1:0]                     line_addr;
  logic [ADDR_BITS-1:0]                     remaining;
  logic [CW-1:0]                            word_cnt;   // words captured this line
  logic [CW-1:0]                            word_idx;   // word being printed
  logic [DW-1:0]                            digit;      // digit within addr/word
  logic                                     flash_stop; // enable dropped for last word
  logic                                     fw_q, nw_q, tw_q;
  logic [WORDS_PER_LINE-1:0][WORD_BITS-1:0] line_buf;

  logic                 fw_rise, nw_rise, tx_rise;
  logic [ADDR_BITS-1:0] line_step;
  logic [CW-1:0]        line_words, last_idx;
  logic [WORD_BITS-1:0] cur_word;
  logic [3:0]           addr_nib, word_nib, hex_nib;
  logic [7:0]           hex_char, low_byte;

  assign fw_rise = in_flash_word_finished & ~fw_q;
  assign nw_rise = in_flash_next_word & ~nw_q;
  assign tx_rise = in_tx_word_finished & ~tw_q;

  // Words in the current line: a full line, or whatever is left.
  assign line_step  = (WPL_FITS && remaining > ADDR_BITS'(WORDS_PER_LINE))
                    ? ADDR_BITS'(WORDS_PER_LINE) : remaining;
  assign line_words = CW'(line_step);
  assign last_idx   = line_words - CW'(1);

  assign cur_word = line_buf[word_idx[IW-1:0]];
  assign addr_nib = 4'(line_addr >> (4 * (ADDR_DIGITS - 1 - int'(digit))));
  assign word_nib = 4'(cur_word >> (4 * (WORD_DIGITS - 1 - int'(digit))));
  assign hex_nib  = (state == S_TX_ADDR) ? addr_nib : word_nib;
  assign low_byte = 8'({8'h00, cur_word});

  hex_digit #(.HEX_UPPER(HEX_UPPER)) u_hex_digit (
    .nibble (hex_nib),
    .ascii  (hex_char)
  );

  // Character on offer is a pure decode of registered state, so it stays
  // stable for the whole handshake.
  always_comb begin
    out_tx_char = CH_SPACE;
    case (state)
      S_TX_ADDR, S_TX_DATA: out_tx_char = hex_char;
      S_TX_COLON:           out_tx_char = CH_COLON;
      S_TX_SEP:             out_tx_char = CH_SPACE;
      S_TX_ASCII_OPEN:      out_tx_char = (digit == '0) ? CH_SPACE : CH_BAR;
      S_TX_ASCII:           out_tx_char = ascii_col(low_byte);
      S_TX_ASCII_CLOSE:     out_tx_char = CH_BAR;
      S_TX_CR:              out_tx_char = CH_CR;
      S_TX_NL:              out_tx_char = CH_NL;
      default:              out_tx_char = CH_SPACE;
    endcase
  end

  // Enables fall combinationally on abort and on the handshake edges so the
  // far side sees the request withdrawn in the same cycle.
  assign out_flash_enable = (state == S_FLASH_READ) && !flash_stop && !in_abort
                          && !(nw_rise && word_cnt == last_idx);
  assign out_tx_enable    = is_tx_state(state) && !tx_rise && !in_abort;
  assign out_busy         = (state != S_IDLE);
  assign out_done         = (state == S_DONE) && !in_abort;
  assign out_flash_addr   = line_addr;

  always_ff @(posedge in_clk or negedge in_rst) begin
    if (!in_rst) begin
      state      <= S_IDLE;
      line_addr  <= '0;
      remaining  <= '0;
      word_cnt   <= '0;
      word_idx   <= '0;
      digit      <= '0;
      flash_stop <= 1'b0;
      fw_q       <= 1'b0;
      nw_q       <= 1'b0;
      tw_q       <= 1'b0;
      line_buf   <= '0;
    end else begin
      fw_q <= in_flash_word_finished;
      nw_q <= in_flash_next_word;
      tw_q <= in_tx_word_finished;

      if (in_abort && state != S_IDLE) begin
        state      <= S_IDLE;
        word_cnt   <= '0;
        word_idx   <= '0;
        digit      <= '0;
        flash_stop <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            if (in_start && !in_abort) begin
              line_addr  <= in_addr;
              remaining  <= in_len;
              word_cnt   <= '0;
              word_idx   <= '0;
              digit      <= '0;
              flash_stop <= 1'b0;
              state      <= (in_len == '0) ? S_DONE : S_FLASH_READ;
            end
          end

          S_FLASH_READ: begin
            if (nw_rise && word_cnt == last_idx) flash_stop <= 1'b1;
            if (fw_rise) begin
              line_buf[word_cnt[IW-1:0]] <= in_flash_data;
              word_cnt <= word_cnt + CW'(1);
              if (word_cnt == last_idx) begin
                flash_stop <= 1'b0;
                digit      <= '0;
                word_idx   <= '0;
                state      <= S_TX_ADDR;
              end
            end
          end

          S_TX_ADDR: if (tx_rise) begin
            if (digit == DW'(ADDR_DIGITS - 1)) begin
              digit <= '0;
              state <= S_TX_COLON;
            end else begin
              digit <= digit + DW'(1);
            end
          end

          S_TX_COLON: if (tx_rise) state <= S_TX_SEP;

          S_TX_SEP: if (tx_rise) begin
            digit <= '0;
            state <= S_TX_DATA;
          end

          S_TX_DATA: if (tx_rise) begin
            if (digit == DW'(WORD_DIGITS - 1)) begin
              digit <= '0;
              if (word_idx == last_idx) begin
                word_idx <= '0;
                state    <= (SHOW_ASCII != 0) ? S_TX_ASCII_OPEN : S_TX_CR;
              end else begin
                word_idx <= word_idx + CW'(1);
                state    <= S_TX_SEP;
              end
            end else begin
              digit <= digit + DW'(1);
            end
          end

          // Two characters: ' ' then '|', tracked with the digit counter.
          S_TX_ASCII_OPEN: if (tx_rise) begin
            if (digit == '0) begin
              digit <= DW'(1);
            end else begin
              digit <= '0;
              state <= S_TX_ASCII;
            end
          end

          S_TX_ASCII: if (tx_rise) begin
            if (word_idx == last_idx) begin
              word_idx <= '0;
              state    <= S_TX_ASCII_CLOSE;
            end else begin
              word_idx <= word_idx + CW'(1);
            end
          end

          S_TX_ASCII_CLOSE: if (tx_rise) state <= S_TX_CR;
          S_TX_CR:          if (tx_rise) state <= S_TX_NL;
          S_TX_NL:          if (tx_rise) state <= S_NEXT_LINE;

          // Address wraps naturally at the register width.
          S_NEXT_LINE: begin
            line_addr <= line_addr + line_step;
            remaining <= remaining - line_step;
            word_cnt  <= '0;
            state     <= (remaining == line_step) ? S_DONE : S_FLASH_READ;
          end

          S_DONE:  state <= S_IDLE;
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule
